// File: rtl/pm_write_player_if.sv
// pm_write_player_if: host command push channel plus the YM2151 CPU bus.
interface pm_write_player_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_ts;
  logic        cmd_a0;
  logic [7:0]  cmd_data;
  logic        ym_cs_n;
  logic        ym_wr_n;
  logic        ym_rd_n;
  logic        ym_a0;
  logic [7:0]  ym_dout;
  logic [7:0]  ym_din;
  modport master (output cmd_valid, cmd_ts, cmd_a0, cmd_data, ym_din,
                  input  cmd_ready, ym_cs_n, ym_wr_n, ym_rd_n, ym_a0, ym_dout);
  modport slave  (input  cmd_valid, cmd_ts, cmd_a0, cmd_data, ym_din,
                  output cmd_ready, ym_cs_n, ym_wr_n, ym_rd_n, ym_a0, ym_dout);
endinterface

// File: rtl/pm_write_player.sv
// pm_write_player: issues timestamped YM2151 writes when the phi-M edge count reaches each timestamp.
// Define PM_WRITE_PLAYER_BUSY_POLL_EN to poll the YM busy flag before every data (a0=1) write.
module pm_write_player #(
  parameter int FIFO_AW  = 4,
  parameter int SETUP_PM = 1,
  parameter int PULSE_PM = 2,
  parameter int HOLD_PM  = 1,
  parameter int GAP_PM   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ym_pm,
  input  logic [31:0]        pm_counter,
  input  logic               enable,
  input  logic               flush,
  pm_write_player_if.slave   bus,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy,
  output logic [15:0]        late_cnt
);
  typedef enum logic [2:0] {IDLE, WAIT_TS, SETUP, STROBE, HOLD, GAP
`ifdef PM_WRITE_PLAYER_BUSY_POLL_EN
    , POLL, PREL
`endif
  } state_t;
  localparam logic [FIFO_AW:0] PTR_ONE = 1;
  state_t state, state_d;
  logic [40:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [31:0] w_ts, diff;
  logic [7:0] w_data, cnt, lim, dout_d, dout_q;
  logic w_a0, first_q, ym_pm_q, pm_rise, ready, push, pop, last;
  logic cs_n_d, wr_n_d, a0_d, cs_n_q, wr_n_q, a0_q, unused_din;
`ifdef PM_WRITE_PLAYER_BUSY_POLL_EN
  logic rd_n_d, rd_n_q, busy_q, abort_q;
`endif
  assign fifo_level    = wr_ptr - rd_ptr;
  assign bus.cmd_ready = !fifo_level[FIFO_AW];
  assign push          = bus.cmd_valid && bus.cmd_ready && !flush;
  assign pop           = state == IDLE && enable && fifo_level != '0 && !flush;
  assign pm_rise       = ym_pm && !ym_pm_q;
  // modular difference keeps the compare correct across pm_counter wrap
  assign diff          = pm_counter - w_ts;
  assign ready         = !diff[31];
  assign busy          = state != IDLE;
  assign unused_din    = ^bus.ym_din;
  assign lim = state == SETUP  ? 8'(SETUP_PM) :
               state == STROBE ? 8'(PULSE_PM) :
               state == HOLD   ? 8'(HOLD_PM)  :
               state == GAP    ? 8'(GAP_PM)   :
`ifdef PM_WRITE_PLAYER_BUSY_POLL_EN
               state == POLL   ? 8'(PULSE_PM) :
`endif
               8'd1;
  assign last = pm_rise && cnt == lim - 8'd1;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {bus.cmd_ts, bus.cmd_a0, bus.cmd_data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ym_pm_q  <= 1'b0;
      cnt      <= '0;
      first_q  <= 1'b0;
      late_cnt <= '0;
      w_ts     <= '0;
      w_a0     <= 1'b0;
      w_data   <= '0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a0_q     <= 1'b0;
      dout_q   <= '0;
`ifdef PM_WRITE_PLAYER_BUSY_POLL_EN
      rd_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      ym_pm_q <= ym_pm;
      rd_ptr  <= flush ? wr_ptr : pop ? rd_ptr + PTR_ONE : rd_ptr;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) {w_ts, w_a0, w_data} <= mem[rd_ptr[FIFO_AW-1:0]];
      first_q <= pop;
      if (state == WAIT_TS && first_q && ready && diff != '0 && !flush && late_cnt != 16'hFFFF)
        late_cnt <= late_cnt + 16'd1;
      cnt     <= last ? 8'd0 : pm_rise ? cnt + 8'd1 : cnt;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      a0_q    <= a0_d;
      dout_q  <= dout_d;
`ifdef PM_WRITE_PLAYER_BUSY_POLL_EN
      rd_n_q  <= rd_n_d;
      if (state == POLL && last) busy_q <= bus.ym_din[7];
      abort_q <= (state_d == POLL || state_d == PREL) && (abort_q || flush);
`endif
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pop) state_d = WAIT_TS;
      WAIT_TS: if (flush) state_d = IDLE;
               else if (ready && pm_rise)
`ifdef PM_WRITE_PLAYER_BUSY_POLL_EN
                 state_d = w_a0 ? POLL : SETUP;
`else
                 state_d = SETUP;
`endif
      SETUP:   if (last) state_d = STROBE;
      STROBE:  if (last) state_d = HOLD;
      HOLD:    if (last) state_d = GAP;
      GAP:     if (last) state_d = IDLE;
`ifdef PM_WRITE_PLAYER_BUSY_POLL_EN
      POLL:    if (last) state_d = PREL;
      PREL:    if (last) state_d = (abort_q || flush) ? IDLE : busy_q ? POLL : SETUP;
`endif
      default: state_d = IDLE;
    endcase
  end
  // outputs are decoded from the next state so the registered bus moves with the state change
  always_comb begin
    cs_n_d = !(state_d == SETUP || state_d == STROBE || state_d == HOLD);
    wr_n_d = state_d != STROBE;
    a0_d   = state_d == SETUP ? w_a0 : a0_q;
    dout_d = state_d == SETUP ? w_data : dout_q;
`ifdef PM_WRITE_PLAYER_BUSY_POLL_EN
    cs_n_d = cs_n_d && state_d != POLL;
    a0_d   = state_d == POLL ? 1'b0 : a0_d;
    rd_n_d = state_d != POLL;
`endif
  end
  assign bus.ym_cs_n = cs_n_q;
  assign bus.ym_wr_n = wr_n_q;
  assign bus.ym_a0   = a0_q;
  assign bus.ym_dout = dout_q;
`ifdef PM_WRITE_PLAYER_BUSY_POLL_EN
  assign bus.ym_rd_n = rd_n_q;
`else
  assign bus.ym_rd_n = 1'b1;
`endif
endmodule

// File: tb/tb_pm_write_player.sv
// tb_pm_write_player: directed checks of write timing, late/wrap handling, FIFO limits, flush and reset.
module tb_pm_write_player;
  logic clk = 1'b0;
  logic rst_n, enable, flush, ym_pm;
  logic [31:0] pm_counter, pm_off, pm_edges = '0;
  logic [1:0] div = '0;
  logic [4:0] fifo_level;
  logic busy;
  logic [15:0] late_cnt;
  int checks = 0, errors = 0, t, cb, rb;
  logic cs_p = 1'b1, wr_p = 1'b1, rd_p = 1'b1;
  int cs_run = 0, wr_run = 0, cs_width = 0, wr_width = 0, cs_falls = 0, rd_falls = 0;
  logic [31:0] cs_fall_pm = '0;
  logic [7:0] cap_data[$];
  logic cap_a0[$];

  pm_write_player_if bus ();

  pm_write_player dut (
    .clk(clk), .rst_n(rst_n), .ym_pm(ym_pm), .pm_counter(pm_counter),
    .enable(enable), .flush(flush), .bus(bus),
    .fifo_level(fifo_level), .busy(busy), .late_cnt(late_cnt)
  );

  always #5 clk = ~clk;

  // phi-M model: period of 4 clk, edge count advances as ym_pm rises
  assign ym_pm = div[1];
  assign pm_counter = pm_off + pm_edges;
  always @(posedge clk) begin
    div <= div + 2'd1;
    if (div == 2'd1) pm_edges <= pm_edges + 32'd1;
  end

  always @(negedge clk) begin
    cs_p   <= bus.ym_cs_n;
    wr_p   <= bus.ym_wr_n;
    rd_p   <= bus.ym_rd_n;
    cs_run <= bus.ym_cs_n ? 0 : cs_run + 1;
    wr_run <= bus.ym_wr_n ? 0 : wr_run + 1;
    if (!cs_p && bus.ym_cs_n) cs_width <= cs_run;
    if (!wr_p && bus.ym_wr_n) wr_width <= wr_run;
    if (cs_p && !bus.ym_cs_n) begin
      cs_falls   <= cs_falls + 1;
      cs_fall_pm <= pm_counter;
    end
    if (wr_p && !bus.ym_wr_n) begin
      cap_data.push_back(bus.ym_dout);
      cap_a0.push_back(bus.ym_a0);
    end
    if (rd_p && !bus.ym_rd_n) rd_falls <= rd_falls + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pm(input logic [31:0] v);
    pm_off = v - pm_edges;
  endtask

  task automatic push(input logic [31:0] ts, input logic a0, input logic [7:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_ts    = ts;
    bus.cmd_a0    = a0;
    bus.cmd_data  = data;
    step(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    t = 0;
    while ((busy || fifo_level != 0) && t < 3000) begin step(1); t++; end
    chk(tag, t < 3000, 1);
    step(2);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; pm_off = '0;
    bus.cmd_valid = 1'b0; bus.cmd_ts = '0; bus.cmd_a0 = 1'b0; bus.cmd_data = '0; bus.ym_din = '0;
    step(3);
    chk("rst_cs_n", bus.ym_cs_n, 1);
    chk("rst_wr_n", bus.ym_wr_n, 1);
    chk("rst_rd_n", bus.ym_rd_n, 1);
    chk("rst_a0", bus.ym_a0, 0);
    chk("rst_dout", bus.ym_dout, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_late", late_cnt, 0);
    rst_n = 1'b1;
    step(2);

    enable = 1'b1;
    set_pm(50);
    cb = cap_data.size();
    push(100, 1'b0, 8'h20);
    t = 0;
    while (bus.ym_cs_n && t < 400) begin step(1); t++; end
    chk("wt_cs_timeout", t < 400, 1);
    wait_idle("wt_idle_timeout");
    chk("wt_cs_fall_pm", cs_fall_pm, 100);
    chk("wt_wr_width", wr_width, 8);
    chk("wt_cs_width", cs_width, 16);
    chk("wt_dout", cap_data[cb], 8'h20);
    chk("wt_a0", cap_a0[cb], 0);
    chk("wt_late", late_cnt, 0);

    set_pm(500);
    cb = cap_data.size();
    push(10, 1'b0, 8'h55);
    wait_idle("late_idle_timeout");
    chk("late_cnt", late_cnt, 1);
    chk("late_dout", cap_data[cb], 8'h55);

    set_pm(32'hFFFF_FFF0);
    t = cs_falls;
    push(5, 1'b0, 8'h66);
    step(40);
    chk("wrap_no_early_cs", cs_falls, t);
    wait_idle("wrap_idle_timeout");
    chk("wrap_cs_fall_pm", cs_fall_pm, 5);
    chk("wrap_late", late_cnt, 1);

    enable = 1'b0;
    cb = cap_data.size();
    for (int i = 0; i < 16; i++) push(pm_counter, 1'b0, 8'h80 + 8'(i));
    chk("full_level", fifo_level, 16);
    chk("full_ready", bus.cmd_ready, 0);
    push(pm_counter, 1'b0, 8'hEE);
    chk("full_drop_level", fifo_level, 16);
    enable = 1'b1;
    wait_idle("full_idle_timeout");
    chk("full_count", cap_data.size() - cb, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("full_data%0d", i), cap_data[cb + i], 8'h80 + 8'(i));

    set_pm(1000);
    t = cs_falls;
    push(2000, 1'b0, 8'h11);
    push(2000, 1'b0, 8'h12);
    step(3);
    chk("fwait_busy", busy, 1);
    chk("fwait_level", fifo_level, 1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("fwait_level_after", fifo_level, 0);
    chk("fwait_busy_after", busy, 0);
    step(40);
    chk("fwait_no_cs", cs_falls, t);

    set_pm(3000);
    cb = cap_data.size();
    push(3000, 1'b0, 8'h33);
    t = 0;
    while (bus.ym_wr_n && t < 100) begin step(1); t++; end
    chk("fstb_wr_timeout", t < 100, 1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    wait_idle("fstb_idle_timeout");
    chk("fstb_wr_width", wr_width, 8);
    chk("fstb_cs_width", cs_width, 16);
    chk("fstb_dout", cap_data[cb], 8'h33);

`ifdef PM_WRITE_PLAYER_BUSY_POLL_EN
    bus.ym_din = 8'h80;
    rb = rd_falls;
    cb = cap_data.size();
    push(pm_counter, 1'b1, 8'h5A);
    t = 0;
    while (rd_falls < rb + 3 && t < 400) begin step(1); t++; end
    chk("poll_rd_timeout", t < 400, 1);
    bus.ym_din = 8'h00;
    wait_idle("poll_idle_timeout");
    chk("poll_rd_count", rd_falls, rb + 3);
    chk("poll_dout", cap_data[cb], 8'h5A);
    chk("poll_a0", cap_a0[cb], 1);
    rb = rd_falls;
    cb = cap_data.size();
    push(pm_counter, 1'b0, 8'h08);
    wait_idle("addr_idle_timeout");
    chk("addr_no_rd", rd_falls, rb);
    chk("addr_dout", cap_data[cb], 8'h08);
`else
    chk("no_poll_rd_falls", rd_falls, 0);
    chk("no_poll_rd_n", bus.ym_rd_n, 1);
`endif

    push(pm_counter, 1'b0, 8'h44);
    t = 0;
    while (bus.ym_wr_n && t < 100) begin step(1); t++; end
    chk("rstb_wr_timeout", t < 100, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstb_cs_n", bus.ym_cs_n, 1);
    chk("rstb_wr_n", bus.ym_wr_n, 1);
    chk("rstb_busy", busy, 0);
    chk("rstb_late", late_cnt, 0);
    chk("rstb_level", fifo_level, 0);
    chk("rstb_ready", bus.cmd_ready, 1);
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
